pio_core: RTL and testbench
===========================

# pio_core

Parametrised command-controlled device: a single-issue core that fetches from an external asynchronous program memory, executes register, ALU, flag and branch instructions, and moves data over a handshaked port bus. It generalises the fixed 4-bit RALU/control-unit pairing in data width, register count and port count. It adds flag-conditional branching, stall-on-port handshakes and a halt state. It sits between the program ROM and the port/peripheral fabric.

## Interface
- WIDTH, 4, data/register width (≥1)
- RA, 3, register address width; 2^RA registers
- PW, 3, port id width (PW ≤ OPW)
- OPW, 8, operand field width and PC width (OPW ≥ WIDTH, RA)
- clock  in  1  rising-edge clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high
- instr_addr  out  OPW  current PC
- instr_data  in  4+RA+OPW  instruction at instr_addr, combinational, same cycle
- data_in  in  WIDTH  port read data
- port_ready  in  1  peripheral completes current read/write
- data_out  out  WIDTH  port write data (registered)
- port_id  out  PW  addressed port (registered)
- port_read, port_write  out  1  port strobes (registered, mutually exclusive)
- carry_flag, zero_flag  out  1  flag registers
- halted  out  1  core in HALTED state

## Operation
- Instruction fields: op = [top 4 bits], rd = next RA bits, operand = low OPW bits; rs = operand[RA-1:0], port = operand[PW-1:0], imm/addr = operand.
- Opcodes: 0 NOP; 1 LDI rd←imm[WIDTH-1:0]; 2 MOV rd←rs; 3 ADD rd←rd+rs, C=carry-out; 4 SUB rd←rd−rs, C=borrow (rd<rs); 5 AND / 6 OR / 7 XOR, C←0; 8 SHL, C←old msb, lsb←0; 9 SHR, C←old lsb, msb←0; A IN rd←port; B OUT port←rd; C JMP addr; D JZ addr; E JC addr; F HALT.
- Arithmetic is modulo 2^WIDTH. Z←(result==0). C and Z update only on opcodes 3–9; all others leave the flags unchanged.
- FSM states: RUN, IN_WAIT, OUT_WAIT, HALTED.
  - RUN: executes the instruction on instr_data.
    - Non-I/O, non-branch: PC←PC+1.
    - Taken branch: PC←addr. Untaken: PC+1.
    - IN → IN_WAIT: port_id←port, port_read←1.
    - OUT → OUT_WAIT: port_id←port, data_out←rd, port_write←1.
    - HALT → HALTED; PC not advanced.
  - IN_WAIT / OUT_WAIT: strobe held, PC held. On port_ready=1: IN writes rd←data_in; strobe←0, PC←PC+1, state→RUN.
  - HALTED: absorbing; leaves only on reset.
- port_id and data_out hold their last values after the strobe drops.
- Register file: 2^RA × WIDTH, no hardwired register; one write per cycle.

## Timing
- Reset: PC=0, all registers=0, flags=0, port_read=port_write=0, port_id=0, data_out=0, halted=0, state RUN.
- Non-I/O instruction: 1 cycle. Result and flags are visible to the next instruction.
- IN/OUT: the strobe rises the cycle after decode. Minimum 2 cycles (port_ready already high). Each extra low cycle of port_ready adds one cycle.
- port_ready is sampled only while a strobe is high; otherwise it is ignored.
- PC wraps 2^OPW−1 → 0. A branch to its own address loops indefinitely.
- Reset asserted during a wait state drops the strobe at that edge; no register write occurs.
- SHL/SHR with WIDTH=1: result 0, C←old bit.

## Structure
- Shared package pio_core_pkg: opcode localparams (OP_NOP..OP_HALT), FSM state encoding, field-offset helper constants.
- Sub-module pio_core_alu: combinational; inputs op, a, b; outputs result and carry. Parametrised by WIDTH.
- Top level holds the FSM, PC, register file, flags and port registers.

## Test plan
- Reset with WIDTH=4 → instr_addr=0, all outputs 0, halted=0. ROM of NOPs → instr_addr increments 0,1,2… one per cycle.
- LDI r1,9; LDI r2,8; ADD r1,r2; OUT r1,port 5 with port_ready=1 → C=1, Z=0; port_write high exactly 1 cycle; data_out=1; port_id=5.
- SUB r1,r1; JZ 0x20 → Z=1, C=0; instr_addr=0x20 on the following cycle. JC 0x40 placed at 0x20 is not taken → 0x21.
- IN r3,port 2; port_ready low for 3 cycles then high; data_in=0xA → port_read high 4 cycles; PC frozen; then OUT r3 shows data_out=0xA. Flags unchanged by IN.
- HALT at 0x05 → halted=1 and instr_addr=0x05 stay fixed for 10 cycles; port_ready pulses have no effect. Reset mid-OUT_WAIT → port_write=0 after that edge, instr_addr=0.
- OPW=8, NOP at 0xFF → instr_addr wraps to 0x00. WIDTH=8 build: LDI 0xFF; ADD with 0x01 → result 0, C=1, Z=1.

Source files
------------

// File: rtl/pio_core_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pio_core_pkg                                                    |
// | Purpose  : Shared opcodes, FSM state encoding and instruction field        |
// |            layout constants for the pio_core command-controlled device.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pio_core_pkg;

  // Width of the opcode field at the top of every instruction word.
  localparam int OP_BITS = 4;

  // Opcode map.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Core sequencing states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IN_WAIT  = 2'd1,
    ST_OUT_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // Instruction word layout: {op, rd, operand}.
  function automatic int instr_width(input int ra, input int opw);
    return OP_BITS + ra + opw;
  endfunction

  // Bit offset of the rd field (it sits directly above the operand).
  function automatic int rd_lsb(input int opw);
    return opw;
  endfunction

  // Bit offset of the opcode field.
  function automatic int op_lsb(input int ra, input int opw);
    return ra + opw;
  endfunction

  // True for opcodes that write C and Z (ADD..SHR).
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage : pio_core_pkg
`default_nettype wire

// File: rtl/pio_core_alu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pio_core_alu                                                    |
// | Purpose  : Combinational ALU for pio_core: add, subtract, logic and        |
// |            single-bit shifts with a carry/borrow output.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pio_core_alu
  import pio_core_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  // One extra bit on each arithmetic path captures carry-out / borrow.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} - {1'b0, b_i};

  // Select the result and carry for the current opcode; non-ALU opcodes
  // produce zeros, which the core never consumes.
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = w_sum[WIDTH-1:0];
        carry_o  = w_sum[WIDTH];
      end
      OP_SUB: begin
        // The borrow lands in the top bit when a < b.
        result_o = w_diff[WIDTH-1:0];
        carry_o  = w_diff[WIDTH];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin
        // With WIDTH=1 the shifted value is 0 and the old bit goes to C.
        result_o = a_i << 1;
        carry_o  = a_i[WIDTH-1];
      end
      OP_SHR: begin
        result_o = a_i >> 1;
        carry_o  = a_i[0];
      end
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule : pio_core_alu
`default_nettype wire

// File: rtl/pio_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pio_core                                                        |
// | Purpose  : Single-issue command-controlled core. Fetches from an async     |
// |            program memory, executes register/ALU/branch instructions and   |
// |            moves data over a handshaked port bus.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pio_core
  import pio_core_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RA    = 3,
  parameter int PW    = 3,
  parameter int OPW   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [OPW-1:0]          instr_addr,
  input  logic [4+RA+OPW-1:0]     instr_data,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    port_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [PW-1:0]           port_id,
  output logic                    port_read,
  output logic                    port_write,
  output logic                    carry_flag,
  output logic                    zero_flag,
  output logic                    halted
);

  localparam int IW     = instr_width(RA, OPW);
  localparam int NREGS  = 1 << RA;
  localparam int OP_LSB = op_lsb(RA, OPW);
  localparam int RD_LSB = rd_lsb(OPW);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [OPW-1:0]    pc_q;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic              carry_q;
  logic              zero_q;
  logic              halted_q;
  logic [RA-1:0]     rd_q;        // destination held across an IN wait
  logic [PW-1:0]     port_id_q;
  logic [WIDTH-1:0]  data_out_q;
  logic              port_read_q;
  logic              port_write_q;

  // ---------------------------------------------------------------------------
  // Instruction decode (the program memory answers in the same cycle)
  // ---------------------------------------------------------------------------
  logic [3:0]        w_op;
  logic [RA-1:0]     w_rd;
  logic [OPW-1:0]    w_operand;
  logic [RA-1:0]     w_rs;
  logic [PW-1:0]     w_port;
  logic [WIDTH-1:0]  w_imm;
  logic [WIDTH-1:0]  w_rd_val;
  logic [WIDTH-1:0]  w_rs_val;
  logic [OPW-1:0]    w_pc_inc;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;

  assign w_op      = instr_data[IW-1:OP_LSB];
  assign w_rd      = instr_data[RD_LSB +: RA];
  assign w_operand = instr_data[OPW-1:0];
  assign w_rs      = w_operand[RA-1:0];
  assign w_port    = w_operand[PW-1:0];
  assign w_imm     = w_operand[WIDTH-1:0];
  assign w_rd_val  = regs_q[w_rd];
  assign w_rs_val  = regs_q[w_rs];

  // PC arithmetic wraps naturally at 2^OPW.
  assign w_pc_inc  = pc_q + OPW'(1);

  pio_core_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i     (w_op),
    .a_i      (w_rd_val),
    .b_i      (w_rs_val),
    .result_o (w_alu_res),
    .carry_o  (w_alu_carry)
  );

  assign w_alu_zero = (w_alu_res == '0);

  // ---------------------------------------------------------------------------
  // Sequencer: FSM, PC, register file, flags and port registers in one place
  // so that every architectural update is visible in a single block.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      halted_q     <= 1'b0;
      rd_q         <= '0;
      port_id_q    <= '0;
      data_out_q   <= '0;
      port_read_q  <= 1'b0;
      port_write_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          case (w_op)
            OP_NOP: begin
              pc_q <= w_pc_inc;
            end
            OP_LDI: begin
              regs_q[w_rd] <= w_imm;
              pc_q         <= w_pc_inc;
            end
            OP_MOV: begin
              regs_q[w_rd] <= w_rs_val;
              pc_q         <= w_pc_inc;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
              regs_q[w_rd] <= w_alu_res;
              carry_q      <= w_alu_carry;
              zero_q       <= w_alu_zero;
              pc_q         <= w_pc_inc;
            end
            OP_IN: begin
              // PC stays on the IN until the peripheral answers.
              port_id_q   <= w_port;
              port_read_q <= 1'b1;
              rd_q        <= w_rd;
              state_q     <= ST_IN_WAIT;
            end
            OP_OUT: begin
              port_id_q    <= w_port;
              data_out_q   <= w_rd_val;
              port_write_q <= 1'b1;
              state_q      <= ST_OUT_WAIT;
            end
            OP_JMP: begin
              pc_q <= w_operand;
            end
            OP_JZ: begin
              pc_q <= zero_q ? w_operand : w_pc_inc;
            end
            OP_JC: begin
              pc_q <= carry_q ? w_operand : w_pc_inc;
            end
            OP_HALT: begin
              // PC is left pointing at the HALT itself.
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end
            default: begin
              pc_q <= w_pc_inc;
            end
          endcase
        end

        ST_IN_WAIT: begin
          if (port_ready) begin
            regs_q[rd_q] <= data_in;
            port_read_q  <= 1'b0;
            pc_q         <= w_pc_inc;
            state_q      <= ST_RUN;
          end
        end

        ST_OUT_WAIT: begin
          if (port_ready) begin
            port_write_q <= 1'b0;
            pc_q         <= w_pc_inc;
            state_q      <= ST_RUN;
          end
        end

        ST_HALTED: begin
          // Absorbing until reset.
          halted_q <= 1'b1;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign instr_addr = pc_q;
  assign data_out   = data_out_q;
  assign port_id    = port_id_q;
  assign port_read  = port_read_q;
  assign port_write = port_write_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign halted     = halted_q;

endmodule : pio_core
`default_nettype wire

// File: tb/tb_pio_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pio_core                                                     |
// | Purpose  : Directed self-checking bench for pio_core with a port-strobe    |
// |            scoreboard, plus a WIDTH=8 instance for the wide-ALU case.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pio_core;
  import pio_core_pkg::*;

  // Main DUT: WIDTH=4, RA=3, PW=3, OPW=8
  logic        clock;
  logic        reset;
  logic [7:0]  instr_addr;
  logic [14:0] instr_data;
  logic [3:0]  data_in;
  logic        port_ready;
  logic [3:0]  data_out;
  logic [2:0]  port_id;
  logic        port_read;
  logic        port_write;
  logic        carry_flag;
  logic        zero_flag;
  logic        halted;

  // Wide DUT: WIDTH=8
  logic [7:0]  instr_addr8;
  logic [14:0] instr_data8;
  logic [7:0]  data_in8;
  logic        port_ready8;
  logic [7:0]  data_out8;
  logic [2:0]  port_id8;
  logic        port_read8;
  logic        port_write8;
  logic        carry_flag8;
  logic        zero_flag8;
  logic        halted8;

  logic [14:0] rom  [256];
  logic [14:0] rom8 [256];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       wr;
    logic [2:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q [$];

  assign instr_data  = rom[instr_addr];
  assign instr_data8 = rom8[instr_addr8];
  assign data_in8    = 8'h00;
  assign port_ready8 = 1'b1;

  pio_core #(.WIDTH(4), .RA(3), .PW(3), .OPW(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .data_in    (data_in),
    .port_ready (port_ready),
    .data_out   (data_out),
    .port_id    (port_id),
    .port_read  (port_read),
    .port_write (port_write),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .halted     (halted)
  );

  pio_core #(.WIDTH(8), .RA(3), .PW(3), .OPW(8)) dut8 (
    .clock      (clock),
    .reset      (reset),
    .instr_addr (instr_addr8),
    .instr_data (instr_data8),
    .data_in    (data_in8),
    .port_ready (port_ready8),
    .data_out   (data_out8),
    .port_id    (port_id8),
    .port_read  (port_read8),
    .port_write (port_write8),
    .carry_flag (carry_flag8),
    .zero_flag  (zero_flag8),
    .halted     (halted8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [7:0] opnd);
    return {op, rd, opnd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  // Scoreboard monitor: every rising port strobe consumes one expectation.
  logic pw_prev = 1'b0;
  logic pr_prev = 1'b0;
  always @(negedge clock) begin
    if ((port_write && !pw_prev) || (port_read && !pr_prev)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got strobe wr=%0b id=%0h expected none", port_write, port_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.wr !== port_write || e.id !== port_id || (e.wr && e.data !== data_out)) begin
          bad++;
          $display("FAIL sb_port: got wr=%0b id=%0h data=%0h expected wr=%0b id=%0h data=%0h",
                   port_write, port_id, data_out, e.wr, e.id, e.data);
        end
      end
    end
    pw_prev <= port_write;
    pr_prev <= port_read;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    port_ready = 1'b1;
    data_in    = 4'h0;
    clear_rom();
    for (int i = 0; i < 256; i++) rom8[i] = '0;
    rom8[0] = ins(OP_LDI, 3'd1, 8'hFF);
    rom8[1] = ins(OP_LDI, 3'd2, 8'h01);
    rom8[2] = ins(OP_ADD, 3'd1, 8'h02);
    rom8[3] = ins(OP_OUT, 3'd1, 8'h00);
    rom8[4] = ins(OP_HALT, 3'd0, 8'h00);

    // ---- Reset state and NOP fetch sequence ----
    step(); step();
    check("rst_addr",  instr_addr, 0);
    check("rst_dout",  data_out,   0);
    check("rst_pid",   port_id,    0);
    check("rst_rd",    port_read,  0);
    check("rst_wr",    port_write, 0);
    check("rst_c",     carry_flag, 0);
    check("rst_z",     zero_flag,  0);
    check("rst_halt",  halted,     0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("nop_addr", instr_addr, i);
      if (i == 3) begin
        check("w8_c", carry_flag8, 1);
        check("w8_z", zero_flag8,  1);
      end
      if (i == 4) begin
        check("w8_wr",   port_write8, 1);
        check("w8_dout", data_out8,   0);
      end
    end

    // ---- ALU, OUT, branches, IN wait ----
    reset = 1'b1;
    clear_rom();
    rom[8'h00] = ins(OP_LDI, 3'd1, 8'h09);
    rom[8'h01] = ins(OP_LDI, 3'd2, 8'h08);
    rom[8'h02] = ins(OP_ADD, 3'd1, 8'h02);
    rom[8'h03] = ins(OP_OUT, 3'd1, 8'h05);
    rom[8'h04] = ins(OP_SUB, 3'd1, 8'h01);
    rom[8'h05] = ins(OP_JZ,  3'd0, 8'h20);
    rom[8'h20] = ins(OP_JC,  3'd0, 8'h40);
    rom[8'h21] = ins(OP_IN,  3'd3, 8'h02);
    rom[8'h22] = ins(OP_OUT, 3'd3, 8'h06);
    rom[8'h23] = ins(OP_HALT, 3'd0, 8'h00);
    step(); step();
    reset      = 1'b0;
    port_ready = 1'b1;
    data_in    = 4'hA;
    exp_q.push_back('{wr: 1'b1, id: 3'd5, data: 4'h1});
    exp_q.push_back('{wr: 1'b0, id: 3'd2, data: 4'h0});
    exp_q.push_back('{wr: 1'b1, id: 3'd6, data: 4'hA});
    step(); step(); step();
    check("add_c",    carry_flag, 1);
    check("add_z",    zero_flag,  0);
    check("add_addr", instr_addr, 8'h03);
    step();
    check("out_wr1",  port_write, 1);
    check("out_pid",  port_id,    5);
    check("out_dout", data_out,   1);
    check("out_addr", instr_addr, 8'h03);
    step();
    check("out_wr0",  port_write, 0);
    check("out_hold", data_out,   1);
    check("out_pc",   instr_addr, 8'h04);
    step();
    check("sub_z",    zero_flag,  1);
    check("sub_c",    carry_flag, 0);
    step();
    check("jz_addr",  instr_addr, 8'h20);
    step();
    check("jc_addr",  instr_addr, 8'h21);
    port_ready = 1'b0;
    step();
    check("in_rd",    port_read,  1);
    check("in_pid",   port_id,    2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("in_rd_hold", port_read,  1);
      check("in_pc_hold", instr_addr, 8'h21);
    end
    port_ready = 1'b1;
    step();
    check("in_rd0",   port_read,  0);
    check("in_pc",    instr_addr, 8'h22);
    check("in_z",     zero_flag,  1);
    check("in_c",     carry_flag, 0);
    step();
    check("out3_wr",   port_write, 1);
    check("out3_dout", data_out,   4'hA);
    step();
    check("out3_pid_hold", port_id, 6);
    step();
    check("halt_flag", halted, 1);

    // ---- HALT at 0x05 is absorbing ----
    reset = 1'b1;
    clear_rom();
    rom[8'h05] = ins(OP_HALT, 3'd0, 8'h00);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_halt", halted, 0);
    step();
    check("halt_set",  halted,     1);
    check("halt_addr", instr_addr, 8'h05);
    for (int i = 0; i < 10; i++) begin
      port_ready = i[0];
      step();
      check("halt_stay", halted,     1);
      check("halt_pc",   instr_addr, 8'h05);
    end

    // ---- Reset during OUT_WAIT ----
    reset = 1'b1;
    clear_rom();
    rom[8'h01] = ins(OP_OUT, 3'd0, 8'h01);
    step(); step();
    reset      = 1'b0;
    port_ready = 1'b0;
    exp_q.push_back('{wr: 1'b1, id: 3'd1, data: 4'h0});
    step();
    check("ow_addr1", instr_addr, 8'h01);
    step();
    check("ow_wr", port_write, 1);
    step();
    check("ow_wr_hold", port_write, 1);
    check("ow_pc_hold", instr_addr, 8'h01);
    reset = 1'b1;
    step();
    check("ow_rst_wr",   port_write, 0);
    check("ow_rst_addr", instr_addr, 8'h00);

    // ---- PC wrap from 0xFF ----
    clear_rom();
    rom[8'h00] = ins(OP_JMP, 3'd0, 8'hFF);
    port_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("jmp_ff", instr_addr, 8'hFF);
    step();
    check("wrap_00", instr_addr, 8'h00);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pio_core
`default_nettype wire
